// File: rtl/fabric_load_arbiter.sv
// rtl/fabric_load_arbiter.sv - round-robin sharing of one memory load port among NUM_PORTS load PEs
// Responses return in issue order; a grant-ID FIFO steers each word back to its PE.
module fabric_load_arbiter #(
    parameter int NUM_PORTS   = 2,
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int QUEUE_DEPTH = 4,
    localparam int ID_W       = $clog2(NUM_PORTS),
    localparam int CNT_W      = $clog2(QUEUE_DEPTH + 1)
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [NUM_PORTS-1:0]             req_valid,
    output logic [NUM_PORTS-1:0]             req_ready,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  req_addr,
    output logic [NUM_PORTS-1:0]             resp_valid,
    input  logic [NUM_PORTS-1:0]             resp_ready,
    output logic [NUM_PORTS*DATA_WIDTH-1:0]  resp_data,
    output logic                             mem_req_valid,
    input  logic                             mem_req_ready,
    output logic [ADDR_WIDTH-1:0]            mem_req_addr,
    input  logic                             mem_resp_valid,
    output logic                             mem_resp_ready,
    input  logic [DATA_WIDTH-1:0]            mem_resp_data,
    output logic [CNT_W-1:0]                 outstanding,
    output logic                             err_unexpected_resp
);

    localparam int PTR_W = $clog2(QUEUE_DEPTH);
    localparam logic [ID_W:0]    NP_W  = (ID_W + 1)'(NUM_PORTS);
    localparam logic [CNT_W-1:0] DEPTH = CNT_W'(QUEUE_DEPTH);

    if (NUM_PORTS < 2) begin : g_bad_ports
        $fatal(1, "fabric_load_arbiter: NUM_PORTS must be >= 2");
    end
    if (QUEUE_DEPTH < 2 || (QUEUE_DEPTH & (QUEUE_DEPTH - 1)) != 0) begin : g_bad_depth
        $fatal(1, "fabric_load_arbiter: QUEUE_DEPTH must be a power of 2 and >= 2");
    end
    if (ADDR_WIDTH < 1 || DATA_WIDTH < 1) begin : g_bad_width
        $fatal(1, "fabric_load_arbiter: ADDR_WIDTH and DATA_WIDTH must be >= 1");
    end

    logic [ID_W-1:0]   rr_ptr;
    logic [ID_W-1:0]   grant;
    logic [ID_W-1:0]   rr_next;
    logic [ID_W-1:0]   head;
    logic [CNT_W-1:0]  count;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [ID_W-1:0]   id_mem [QUEUE_DEPTH];
    logic              fifo_full;
    logic              fifo_empty;
    logic              push;
    logic              pop;

    assign fifo_full  = (count == DEPTH);
    assign fifo_empty = (count == '0);
    assign head       = id_mem[rd_ptr];

    // Scan from rr_ptr upward with wrap; the first requester wins.
    always_comb begin : arb
        logic [ID_W:0] idx;
        logic          found;
        grant = rr_ptr;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            idx = {1'b0, rr_ptr} + (ID_W + 1)'(k);
            if (idx >= NP_W) begin
                idx = idx - NP_W;
            end
            if (!found && req_valid[idx[ID_W-1:0]]) begin
                grant = idx[ID_W-1:0];
                found = 1'b1;
            end
        end
    end

    always_comb begin : rr_advance
        logic [ID_W:0] nxt;
        nxt = {1'b0, grant} + (ID_W + 1)'(1);
        if (nxt >= NP_W) begin
            nxt = '0;
        end
        rr_next = nxt[ID_W-1:0];
    end

    always_comb begin
        mem_req_addr = '0;
        req_ready    = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (grant == ID_W'(i)) begin
                mem_req_addr = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                req_ready[i] = mem_req_ready && !fifo_full;
            end
        end
    end

    assign mem_req_valid = (|req_valid) && !fifo_full;
    assign push          = mem_req_valid && mem_req_ready;

    // Response path is pure pass-through: data is never buffered here.
    always_comb begin
        resp_valid = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            resp_valid[i] = mem_resp_valid && !fifo_empty && (head == ID_W'(i));
        end
    end

    assign resp_data      = {NUM_PORTS{mem_resp_data}};
    assign mem_resp_ready = !fifo_empty && resp_ready[head];
    assign pop            = mem_resp_valid && mem_resp_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr              <= '0;
            wr_ptr              <= '0;
            rd_ptr              <= '0;
            count               <= '0;
            err_unexpected_resp <= 1'b0;
        end else begin
            if (push) begin
                rr_ptr <= rr_next;
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            if (mem_resp_valid && fifo_empty) begin
                err_unexpected_resp <= 1'b1;
            end
        end
    end

    // ID storage needs no reset: entries are only read behind a valid count.
    always_ff @(posedge clk) begin
        if (push) begin
            id_mem[wr_ptr] <= grant;
        end
    end

    assign outstanding = count;

endmodule

// File: tb/tb_fabric_load_arbiter.sv
// tb/tb_fabric_load_arbiter.sv - scoreboard bench for fabric_load_arbiter
module tb_fabric_load_arbiter;

    localparam int NP    = 4;
    localparam int AW    = 16;
    localparam int DW    = 16;
    localparam int QD    = 4;
    localparam int CNT_W = $clog2(QD + 1);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst_n;
    logic [NP-1:0]        req_valid;
    logic [NP-1:0]        req_ready;
    logic [NP*AW-1:0]     req_addr;
    logic [NP-1:0]        resp_valid;
    logic [NP-1:0]        resp_ready;
    logic [NP*DW-1:0]     resp_data;
    logic                 mem_req_valid;
    logic                 mem_req_ready;
    logic [AW-1:0]        mem_req_addr;
    logic                 mem_resp_valid;
    logic                 mem_resp_ready;
    logic [DW-1:0]        mem_resp_data;
    logic [CNT_W-1:0]     outstanding;
    logic                 err_unexpected_resp;

    typedef struct {
        int            port;
        logic [DW-1:0] data;
    } exp_t;

    exp_t          sb[$];
    logic [DW-1:0] mem_q[$];
    int            vectors     = 0;
    int            miscompares = 0;

    fabric_load_arbiter #(
        .NUM_PORTS  (NP),
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .QUEUE_DEPTH(QD)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .req_valid          (req_valid),
        .req_ready          (req_ready),
        .req_addr           (req_addr),
        .resp_valid         (resp_valid),
        .resp_ready         (resp_ready),
        .resp_data          (resp_data),
        .mem_req_valid      (mem_req_valid),
        .mem_req_ready      (mem_req_ready),
        .mem_req_addr       (mem_req_addr),
        .mem_resp_valid     (mem_resp_valid),
        .mem_resp_ready     (mem_resp_ready),
        .mem_resp_data      (mem_resp_data),
        .outstanding        (outstanding),
        .err_unexpected_resp(err_unexpected_resp)
    );

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle_inputs();
        req_valid      = '0;
        resp_ready     = '0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_data  = '0;
        req_addr       = {16'h0103, 16'h0102, 16'h0101, 16'h0100};
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        sb.delete();
        mem_q.delete();
    endtask

    // Memory model: the word it will return for this request, and who should get it.
    task automatic expect_issue(input int p, input logic [DW-1:0] d);
        exp_t e;
        e.port = p;
        e.data = d;
        sb.push_back(e);
        mem_q.push_back(d);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        #3;
        vectors++; if (outstanding !== '0) begin miscompares++; $display("FAIL reset_outstanding: got %0d want 0", outstanding); end
        vectors++; if (err_unexpected_resp !== 1'b0) begin miscompares++; $display("FAIL reset_err: got %b want 0", err_unexpected_resp); end
        vectors++; if (mem_req_valid !== 1'b0) begin miscompares++; $display("FAIL reset_mem_req_valid: got %b want 0", mem_req_valid); end
        vectors++; if (req_ready !== '0) begin miscompares++; $display("FAIL reset_req_ready: got %b want 0000", req_ready); end
        vectors++; if (resp_valid !== '0) begin miscompares++; $display("FAIL reset_resp_valid: got %b want 0000", resp_valid); end
        vectors++; if (mem_resp_ready !== 1'b0) begin miscompares++; $display("FAIL reset_mem_resp_ready: got %b want 0", mem_resp_ready); end
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        #1;
        vectors++; if (outstanding !== '0) begin miscompares++; $display("FAIL reset_release_outstanding: got %0d want 0", outstanding); end
    endtask

    task automatic test_single_pe();
        exp_t e;
        do_reset();
        req_valid       = 4'b0001;
        req_addr[15:0]  = 16'h0010;
        mem_req_ready   = 1'b1;
        resp_ready      = '1;
        #1;
        vectors++; if (mem_req_valid !== 1'b1) begin miscompares++; $display("FAIL single_mem_req_valid: got %b want 1", mem_req_valid); end
        vectors++; if (mem_req_addr !== 16'h0010) begin miscompares++; $display("FAIL single_addr: got %h want 0010", mem_req_addr); end
        vectors++; if (req_ready !== 4'b0001) begin miscompares++; $display("FAIL single_req_ready: got %b want 0001", req_ready); end
        expect_issue(0, 16'h00AA);
        tick();
        req_valid = '0;
        #1;
        vectors++; if (outstanding !== CNT_W'(1)) begin miscompares++; $display("FAIL single_outstanding_1: got %0d want 1", outstanding); end
        tick();
        mem_resp_valid = 1'b1;
        mem_resp_data  = mem_q[0];
        #1;
        e = sb[0];
        vectors++; if (resp_valid !== (NP'(1) << e.port)) begin miscompares++; $display("FAIL single_resp_valid: got %b want port %0d", resp_valid, e.port); end
        vectors++; if (resp_data[e.port*DW +: DW] !== e.data) begin miscompares++; $display("FAIL single_resp_data: got %h want %h", resp_data[e.port*DW +: DW], e.data); end
        vectors++; if (mem_resp_ready !== 1'b1) begin miscompares++; $display("FAIL single_mem_resp_ready: got %b want 1", mem_resp_ready); end
        void'(sb.pop_front());
        void'(mem_q.pop_front());
        tick();
        mem_resp_valid = 1'b0;
        #1;
        vectors++; if (outstanding !== '0) begin miscompares++; $display("FAIL single_outstanding_0: got %0d want 0", outstanding); end
    endtask

    task automatic test_round_robin();
        exp_t e;
        logic had_resp;
        do_reset();
        req_valid     = '1;
        mem_req_ready = 1'b1;
        resp_ready    = '1;
        for (int k = 0; k < 5; k++) begin
            had_resp = (mem_q.size() > 0);
            mem_resp_valid = had_resp;
            mem_resp_data  = had_resp ? mem_q[0] : '0;
            #1;
            vectors++; if (mem_req_addr !== AW'(16'h0100 + (k % NP))) begin miscompares++; $display("FAIL rr_addr[%0d]: got %h want %h", k, mem_req_addr, 16'h0100 + (k % NP)); end
            vectors++; if (req_ready !== (NP'(1) << (k % NP))) begin miscompares++; $display("FAIL rr_grant[%0d]: got %b want port %0d", k, req_ready, k % NP); end
            if (had_resp) begin
                e = sb[0];
                vectors++; if (resp_valid !== (NP'(1) << e.port)) begin miscompares++; $display("FAIL rr_resp_valid[%0d]: got %b want port %0d", k, resp_valid, e.port); end
                vectors++; if (resp_data[e.port*DW +: DW] !== e.data) begin miscompares++; $display("FAIL rr_resp_data[%0d]: got %h want %h", k, resp_data[e.port*DW +: DW], e.data); end
                void'(sb.pop_front());
                void'(mem_q.pop_front());
            end
            expect_issue(k % NP, DW'(16'h2000 + k));
            tick();
        end
        req_valid      = '0;
        mem_resp_valid = 1'b1;
        mem_resp_data  = mem_q[0];
        #1;
        e = sb[0];
        vectors++; if (resp_valid !== (NP'(1) << e.port)) begin miscompares++; $display("FAIL rr_last_resp_valid: got %b want port %0d", resp_valid, e.port); end
        void'(sb.pop_front());
        void'(mem_q.pop_front());
        tick();
        mem_resp_valid = 1'b0;
        #1;
        vectors++; if (outstanding !== '0) begin miscompares++; $display("FAIL rr_outstanding: got %0d want 0", outstanding); end
    endtask

    task automatic test_in_order_routing();
        exp_t e;
        do_reset();
        mem_req_ready = 1'b1;
        resp_ready    = '1;
        req_valid     = 4'b0100;
        #1;
        vectors++; if (req_ready !== 4'b0100) begin miscompares++; $display("FAIL route_grant_pe2: got %b want 0100", req_ready); end
        vectors++; if (mem_req_addr !== 16'h0102) begin miscompares++; $display("FAIL route_addr_pe2: got %h want 0102", mem_req_addr); end
        expect_issue(2, 16'hD0D0);
        tick();
        req_valid = 4'b0001;
        #1;
        vectors++; if (req_ready !== 4'b0001) begin miscompares++; $display("FAIL route_grant_pe0: got %b want 0001", req_ready); end
        expect_issue(0, 16'hD1D1);
        tick();
        req_valid = '0;
        for (int k = 0; k < 2; k++) begin
            mem_resp_valid = 1'b1;
            mem_resp_data  = mem_q[0];
            #1;
            e = sb[0];
            vectors++; if (resp_valid !== (NP'(1) << e.port)) begin miscompares++; $display("FAIL route_resp_valid[%0d]: got %b want port %0d", k, resp_valid, e.port); end
            vectors++; if (resp_data[e.port*DW +: DW] !== e.data) begin miscompares++; $display("FAIL route_resp_data[%0d]: got %h want %h", k, resp_data[e.port*DW +: DW], e.data); end
            void'(sb.pop_front());
            void'(mem_q.pop_front());
            tick();
        end
        mem_resp_valid = 1'b0;
    endtask

    task automatic test_fifo_full();
        exp_t e;
        do_reset();
        req_valid     = 4'b0001;
        mem_req_ready = 1'b1;
        resp_ready    = '1;
        for (int k = 0; k < QD; k++) begin
            #1;
            vectors++; if (mem_req_valid !== 1'b1) begin miscompares++; $display("FAIL full_issue[%0d]: got %b want 1", k, mem_req_valid); end
            expect_issue(0, DW'(16'h4000 + k));
            tick();
        end
        #1;
        vectors++; if (outstanding !== CNT_W'(QD)) begin miscompares++; $display("FAIL full_outstanding: got %0d want %0d", outstanding, QD); end
        vectors++; if (mem_req_valid !== 1'b0) begin miscompares++; $display("FAIL full_blocks_valid: got %b want 0", mem_req_valid); end
        vectors++; if (req_ready !== '0) begin miscompares++; $display("FAIL full_blocks_ready: got %b want 0000", req_ready); end
        tick();
        mem_resp_valid = 1'b1;
        mem_resp_data  = mem_q[0];
        #1;
        e = sb[0];
        vectors++; if (mem_req_valid !== 1'b0) begin miscompares++; $display("FAIL full_no_bypass: got %b want 0", mem_req_valid); end
        vectors++; if (mem_resp_ready !== 1'b1) begin miscompares++; $display("FAIL full_pop_ready: got %b want 1", mem_resp_ready); end
        vectors++; if (resp_data[e.port*DW +: DW] !== e.data) begin miscompares++; $display("FAIL full_resp_data: got %h want %h", resp_data[e.port*DW +: DW], e.data); end
        void'(sb.pop_front());
        void'(mem_q.pop_front());
        tick();
        mem_resp_valid = 1'b0;
        #1;
        vectors++; if (outstanding !== CNT_W'(QD - 1)) begin miscompares++; $display("FAIL full_after_pop: got %0d want %0d", outstanding, QD - 1); end
        vectors++; if (req_ready !== 4'b0001) begin miscompares++; $display("FAIL full_resume: got %b want 0001", req_ready); end
        expect_issue(0, 16'h4004);
        tick();
        req_valid = '0;
        for (int k = 0; k < QD; k++) begin
            mem_resp_valid = 1'b1;
            mem_resp_data  = mem_q[0];
            #1;
            e = sb[0];
            vectors++; if (resp_data[e.port*DW +: DW] !== e.data || resp_valid !== (NP'(1) << e.port)) begin miscompares++; $display("FAIL full_drain[%0d]: got %b/%h want port %0d data %h", k, resp_valid, resp_data[e.port*DW +: DW], e.port, e.data); end
            void'(sb.pop_front());
            void'(mem_q.pop_front());
            tick();
        end
        mem_resp_valid = 1'b0;
        #1;
        vectors++; if (outstanding !== '0) begin miscompares++; $display("FAIL full_drained: got %0d want 0", outstanding); end
    endtask

    task automatic test_resp_backpressure();
        exp_t e;
        do_reset();
        mem_req_ready = 1'b1;
        resp_ready    = 4'b1101;
        req_valid     = 4'b0010;
        #1;
        expect_issue(1, 16'h5000);
        tick();
        for (int h = 0; h < 3; h++) begin
            mem_resp_valid = 1'b1;
            mem_resp_data  = mem_q[0];
            #1;
            e = sb[0];
            vectors++; if (mem_resp_ready !== 1'b0) begin miscompares++; $display("FAIL bp_stall[%0d]: got %b want 0", h, mem_resp_ready); end
            vectors++; if (resp_valid !== 4'b0010 || resp_data[DW +: DW] !== e.data) begin miscompares++; $display("FAIL bp_held[%0d]: got %b/%h want 0010/%h", h, resp_valid, resp_data[DW +: DW], e.data); end
            vectors++; if (mem_req_valid !== 1'b1) begin miscompares++; $display("FAIL bp_issue[%0d]: got %b want 1", h, mem_req_valid); end
            expect_issue(1, DW'(16'h5001 + h));
            tick();
        end
        resp_ready = '1;
        #1;
        e = sb[0];
        vectors++; if (mem_resp_ready !== 1'b1) begin miscompares++; $display("FAIL bp_release: got %b want 1", mem_resp_ready); end
        vectors++; if (mem_req_valid !== 1'b0 || outstanding !== CNT_W'(QD)) begin miscompares++; $display("FAIL bp_full: got valid %b count %0d want 0/%0d", mem_req_valid, outstanding, QD); end
        vectors++; if (resp_data[e.port*DW +: DW] !== e.data) begin miscompares++; $display("FAIL bp_data: got %h want %h", resp_data[e.port*DW +: DW], e.data); end
        void'(sb.pop_front());
        void'(mem_q.pop_front());
        tick();
        req_valid = '0;
        for (int k = 0; k < QD - 1; k++) begin
            mem_resp_valid = 1'b1;
            mem_resp_data  = mem_q[0];
            #1;
            e = sb[0];
            vectors++; if (resp_data[e.port*DW +: DW] !== e.data || resp_valid !== (NP'(1) << e.port)) begin miscompares++; $display("FAIL bp_drain[%0d]: got %b/%h want port %0d data %h", k, resp_valid, resp_data[e.port*DW +: DW], e.port, e.data); end
            void'(sb.pop_front());
            void'(mem_q.pop_front());
            tick();
        end
        mem_resp_valid = 1'b0;
        #1;
        vectors++; if (outstanding !== '0) begin miscompares++; $display("FAIL bp_drained: got %0d want 0", outstanding); end
    endtask

    task automatic test_unexpected_and_reset();
        do_reset();
        mem_resp_valid = 1'b1;
        mem_resp_data  = 16'hDEAD;
        #1;
        vectors++; if (mem_resp_ready !== 1'b0 || resp_valid !== '0) begin miscompares++; $display("FAIL stray_stalled: got ready %b valid %b want 0/0000", mem_resp_ready, resp_valid); end
        vectors++; if (err_unexpected_resp !== 1'b0) begin miscompares++; $display("FAIL stray_err_early: got %b want 0", err_unexpected_resp); end
        tick();
        #1;
        vectors++; if (err_unexpected_resp !== 1'b1) begin miscompares++; $display("FAIL stray_err_set: got %b want 1", err_unexpected_resp); end
        mem_resp_valid = 1'b0;
        repeat (3) tick();
        #1;
        vectors++; if (err_unexpected_resp !== 1'b1) begin miscompares++; $display("FAIL stray_err_sticky: got %b want 1", err_unexpected_resp); end
        req_valid     = '1;
        mem_req_ready = 1'b1;
        resp_ready    = '1;
        tick();
        tick();
        #1;
        vectors++; if (outstanding !== CNT_W'(2)) begin miscompares++; $display("FAIL burst_outstanding: got %0d want 2", outstanding); end
        rst_n = 1'b0;
        #1;
        vectors++; if (outstanding !== '0 || err_unexpected_resp !== 1'b0) begin miscompares++; $display("FAIL midreset_clear: got count %0d err %b want 0/0", outstanding, err_unexpected_resp); end
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        #1;
        vectors++; if (req_ready !== 4'b0001 || mem_req_addr !== 16'h0100) begin miscompares++; $display("FAIL midreset_rr_ptr: got %b/%h want 0001/0100", req_ready, mem_req_addr); end
        req_valid = '0;
        sb.delete();
        mem_q.delete();
    endtask

    initial begin
        test_reset();
        test_single_pe();
        test_round_robin();
        test_in_order_routing();
        test_fifo_full();
        test_resp_backpressure();
        test_unexpected_and_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
